mem_arb2: RTL
=============

# mem_arb2

Two-client round-robin arbiter that shares the single write port and single read port of the team's 8 x 16-bit register-file memory between two requesters. Each client issues one read or write at a time with a req/ack handshake. The arbiter drives the memory's write-enable, write-address, write-data and read-address inputs, and routes the registered read data back to the client that owns it. It sits between the two client blocks and one memory instance. All ports of that memory run on this block's `clk`.

## Interface
Parameters:
- `ADDR_W`, default 3: memory address width (depth 2^ADDR_W).
- `DATA_W`, default 16: memory data width.

Ports:
- `clk`  in  1  sole clock; rising edge; also feeds the memory's `wr_clk` and `rd_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  client request; held high until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1`  in  ADDR_W  transaction address; stable while req is high.
- `wdata0`, `wdata1`  in  DATA_W  write data; stable while req is high.
- `ack0`, `ack1`  out  1  one-cycle grant acknowledge.
- `rvalid0`, `rvalid1`  out  1  one-cycle read-data-valid strobe.
- `rdata`  out  DATA_W  read data, shared by both clients; pass-through of `mem_rdata`.
- `mem_wr_en`  out  1  memory write enable.
- `mem_wr_addr`  out  ADDR_W  memory write address.
- `mem_data`  out  DATA_W  memory write data.
- `mem_rd_addr`  out  ADDR_W  memory read address.
- `mem_rdata`  in  DATA_W  memory registered output (`mem_out`).

## Operation
Eligibility:
- Client i is eligible at an edge when `req_i` = 1 and `ack_i` = 0 in the current cycle.
- This prevents a re-grant while the client is dropping req.

Arbitration:
- At most one grant per edge.
- If only one client is eligible, it wins.
- If both are eligible, the winner is the client not granted last (pointer `last`). After reset `last` = 1, so client 0 wins the first tie.
- `last` updates only when a grant occurs.

Grant actions (all registered):
- `ack_w` = 1 for one cycle.
- Write: `mem_wr_en` = 1, `mem_wr_addr` = `addr_w`, `mem_data` = `wdata_w`.
- Read: `mem_wr_en` = 0, `mem_rd_addr` = `addr_w`, and a 2-stage owner/valid pipeline is loaded with the winner's ID.

No grant:
- `mem_wr_en` = 0 and `ack*` = 0.
- `mem_wr_addr`, `mem_data` and `mem_rd_addr` hold their previous values.

Read return:
- The pipeline's second stage drives `rvalid_owner` = 1.
- `rdata` = `mem_rdata` combinationally.
- Writes never produce rvalid.

Reset (async assert, `rst_n` = 0):
- All outputs are 0 except `rdata`, which follows memory.
- `last` = 1; pipeline cleared.
- Any in-flight read is discarded and its rvalid is never issued.
- Memory contents are not touched.

Throughput:
- Up to one transaction per cycle aggregate.
- Per client, one per 2 cycles because of the eligibility rule.

## Timing
- Cycle N: `req_i` high and eligible; grant decided at the end-of-N edge.
- Cycle N+1: `ack_i` = 1 and memory inputs valid; the memory writes or samples the read address at the end-of-N+1 edge.
- Cycle N+2: for a read, `rvalid_i` = 1 and `rdata` is valid. Read latency is 2 cycles from the grant edge.
- A client may drop req, or present a new request, in cycle N+2 at the earliest.
- Read-after-write to the same address, with the read granted on the edge after the write grant, returns the new data.
- Write and read granted on consecutive edges, in either order, never conflict, because at most one grant is made per edge.
- Reset deasserted mid-request: arbitration resumes at the first rising edge after release, with client 0 favoured.

## Test plan
- Reset, then client 0 reads address 0 with memory preloaded to 16'habcd:
  - `ack0` = 1 in cycle N+1, `mem_rd_addr` = 0;
  - `rvalid0` = 1 with `rdata` = 16'habcd in cycle N+2;
  - `rvalid1` stays 0.
- Client 1 writes 16'h1234 to address 5, then reads address 5 on its next eligible cycle:
  - `mem_wr_en` = 1 and `mem_wr_addr` = 5 for exactly one cycle;
  - the read returns 16'h1234 with `rvalid1`.
- Both clients hold reads continuously (addr0 = 2, addr1 = 7) for 8 cycles after reset:
  - grants alternate 0,1,0,1…;
  - `rvalid0` returns 16'h1358 and `rvalid1` returns 16'hc0d1, each with exactly 2-cycle latency;
  - one ack per cycle.
- Simultaneous write (client 0: addr 3, 16'hffff) and read (client 1: addr 3) with `last` = 1:
  - the write is granted first, the read second;
  - the read returns 16'hffff.
- Assert `rst_n` = 0 asynchronously one cycle after a read grant:
  - all ack, rvalid and `mem_wr_en` outputs drop immediately;
  - no rvalid appears after release;
  - the first post-reset tie goes to client 0.
- Client holds req through its ack cycle:
  - no second ack the following cycle;
  - re-grant occurs only after the ack cycle, i.e. acks are at least 2 cycles apart for one client.

Source files
------------

// File: rtl/mem_arb2.sv
// Two-client round-robin arbiter sharing one write port and one read port of a
// registered-output register-file memory, with a 2-stage read-return pipeline.
module mem_arb2 #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              last_q, last_d;
  logic              p1_valid_q, p1_valid_d;
  logic              p1_owner_q, p1_owner_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;

  logic              elig0, elig1, gnt0, gnt1, win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // A client in its ack cycle is not eligible, so a held req is never granted twice.
  always_comb begin
    elig0     = req0 & ~ack0_q;
    elig1     = req1 & ~ack1_q;
    gnt0      = elig0 & (~elig1 | last_q);
    gnt1      = elig1 & ~gnt0;
    win_we    = gnt0 ? we0    : we1;
    win_addr  = gnt0 ? addr0  : addr1;
    win_wdata = gnt0 ? wdata0 : wdata1;

    ack0_d     = gnt0;
    ack1_d     = gnt1;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wdata_d    = wdata_q;
    rd_addr_d  = rd_addr_q;
    last_d     = last_q;
    p1_valid_d = 1'b0;
    p1_owner_d = p1_owner_q;
    rvalid0_d  = p1_valid_q & ~p1_owner_q;
    rvalid1_d  = p1_valid_q & p1_owner_q;

    if (gnt0 | gnt1) begin
      last_d = gnt1;
      if (win_we) begin
        wr_en_d   = 1'b1;
        wr_addr_d = win_addr;
        wdata_d   = win_wdata;
      end else begin
        rd_addr_d  = win_addr;
        p1_valid_d = 1'b1;
        p1_owner_d = gnt1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wdata_q    <= '0;
      rd_addr_q  <= '0;
      last_q     <= 1'b1;
      p1_valid_q <= 1'b0;
      p1_owner_q <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wdata_q    <= wdata_d;
      rd_addr_q  <= rd_addr_d;
      last_q     <= last_d;
      p1_valid_q <= p1_valid_d;
      p1_owner_q <= p1_owner_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata       = mem_rdata;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_data    = wdata_q;
  assign mem_rd_addr = rd_addr_q;

endmodule
